// File: rtl/blackjack_pkg.sv
// Shared blackjack definitions: deck geometry, shoe FSM states and the
// rank-to-value mapping used by both the shoe and the game FSM.
package blackjack_pkg;

  localparam int DECK_SIZE  = 52;
  localparam int RANKS      = 13;
  localparam int FACE_VALUE = 10;

  typedef enum logic [1:0] {
    READY   = 2'd0,
    SHUFFLE = 2'd1,
    PROBE   = 2'd2,
    DELIVER = 2'd3
  } shoe_state_t;

  // Blackjack value of a rank 1..13: Ace counts 1 here, J/Q/K count 10.
  function automatic logic [3:0] rank_to_value(input logic [3:0] rank);
    return (rank > 4'(FACE_VALUE)) ? 4'(FACE_VALUE) : rank;
  endfunction

endpackage

// File: rtl/card_lfsr16.sv
// 16-bit Galois LFSR (taps 16'hB400) that advances every cycle; it is the
// randomness source for picking a starting card slot in the shoe.
module card_lfsr16 #(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        reset,
  output logic [15:0] state_o
);

  localparam logic [15:0] TAPS = 16'hB400;

  logic [15:0] state_q;
  logic [15:0] state_d;

  // Right-shifting Galois step: the bit shifted out feeds back into the taps.
  always_comb begin
    state_d = {1'b0, state_q[15:1]} ^ (state_q[0] ? TAPS : 16'h0000);
  end

  // State register; the seed must be non-zero or the sequence locks at zero.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= SEED;
    end else begin
      state_q <= state_d;
    end
  end

  assign state_o = state_q;

endmodule

// File: rtl/card_shoe.sv
// Single 52-card shoe dealing without replacement. A draw picks a starting
// slot (LFSR or fixed order) and probes forward past already-dealt slots
// until it finds an undealt card, which is then presented for one cycle.
module card_shoe
  import blackjack_pkg::*;
#(
  parameter logic [15:0] LFSR_SEED = 16'hACE1,
  parameter int          LOW_MARK  = 13
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       draw_req,
  input  logic       shuffle_req,
  input  logic       test_mode,
  output logic       ready,
  output logic       card_valid,
  output logic [3:0] card_rank,
  output logic [3:0] card_value,
  output logic [5:0] cards_left,
  output logic       low_cards
);

  shoe_state_t state_q, state_d;
  logic [DECK_SIZE-1:0] used_q, used_d;
  logic [5:0]  cards_left_q, cards_left_d;
  logic [5:0]  probe_idx_q, probe_idx_d;
  logic        pending_q, pending_d;      // draw waiting behind an auto-reshuffle
  logic        pend_test_q, pend_test_d;  // test_mode captured with that draw
  logic [3:0]  rank_q, rank_d;
  logic [3:0]  value_q, value_d;
  logic        valid_q;
  logic        low_q;

  logic [15:0] lfsr_state;
  logic [5:0]  candidate;
  logic [3:0]  probe_rank;
  logic        probe_hit;
  logic        clear_mask;
  logic        lfsr_unused;

  card_lfsr16 #(
    .SEED(LFSR_SEED)
  ) u_lfsr (
    .clk    (clk),
    .reset  (reset),
    .state_o(lfsr_state)
  );

  // Only the low six LFSR bits choose a slot; the rest are deliberately dropped.
  assign lfsr_unused = ^lfsr_state[15:6];

  // Fold 52..63 back into 0..11 so every raw value maps to a real slot.
  assign candidate = (lfsr_state[5:0] >= 6'(DECK_SIZE)) ?
                     (lfsr_state[5:0] - 6'(DECK_SIZE)) : lfsr_state[5:0];

  // Slot index to rank: suits are laid out as consecutive runs of 13.
  assign probe_rank = 4'(probe_idx_q % 6'(RANKS)) + 4'd1;

  // Next-state logic for the shoe FSM and its datapath registers.
  always_comb begin
    state_d      = state_q;
    cards_left_d = cards_left_q;
    probe_idx_d  = probe_idx_q;
    pending_d    = pending_q;
    pend_test_d  = pend_test_q;
    rank_d       = rank_q;
    value_d      = value_q;
    probe_hit    = 1'b0;
    clear_mask   = 1'b0;

    case (state_q)
      READY: begin
        if (shuffle_req) begin
          // A simultaneous draw is discarded; the shuffle takes priority.
          state_d = SHUFFLE;
        end else if (draw_req) begin
          if (cards_left_q != 6'd0) begin
            state_d     = PROBE;
            probe_idx_d = test_mode ? (6'(DECK_SIZE) - cards_left_q) : candidate;
          end else begin
            // Empty shoe: reshuffle first, then serve the draw.
            state_d     = SHUFFLE;
            pending_d   = 1'b1;
            pend_test_d = test_mode;
          end
        end
      end

      SHUFFLE: begin
        clear_mask   = 1'b1;
        cards_left_d = 6'(DECK_SIZE);
        if (pending_q) begin
          state_d     = PROBE;
          pending_d   = 1'b0;
          probe_idx_d = pend_test_q ? 6'd0 : candidate;
        end else begin
          state_d = READY;
        end
      end

      PROBE: begin
        if (!used_q[probe_idx_q]) begin
          probe_hit    = 1'b1;
          rank_d       = probe_rank;
          value_d      = rank_to_value(probe_rank);
          cards_left_d = cards_left_q - 6'd1;
          state_d      = DELIVER;
        end else begin
          probe_idx_d = (probe_idx_q == 6'(DECK_SIZE - 1)) ? 6'd0 : (probe_idx_q + 6'd1);
        end
      end

      DELIVER: begin
        state_d = READY;
      end

      default: begin
        state_d = READY;
      end
    endcase
  end

  // Per-slot used bits: cleared by a shuffle, set when the probe claims the slot.
  for (genvar gi = 0; gi < DECK_SIZE; gi++) begin : g_used
    assign used_d[gi] = clear_mask ? 1'b0 :
                        (used_q[gi] | (probe_hit && (probe_idx_q == 6'(gi))));
  end

  // State and output registers; card_valid and low_cards look one step ahead
  // so they line up with the DELIVER cycle and the updated count.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= READY;
      used_q       <= '0;
      cards_left_q <= 6'(DECK_SIZE);
      probe_idx_q  <= 6'd0;
      pending_q    <= 1'b0;
      pend_test_q  <= 1'b0;
      rank_q       <= 4'd0;
      value_q      <= 4'd0;
      valid_q      <= 1'b0;
      low_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      used_q       <= used_d;
      cards_left_q <= cards_left_d;
      probe_idx_q  <= probe_idx_d;
      pending_q    <= pending_d;
      pend_test_q  <= pend_test_d;
      rank_q       <= rank_d;
      value_q      <= value_d;
      valid_q      <= (state_d == DELIVER);
      low_q        <= (cards_left_d <= 6'(LOW_MARK));
    end
  end

  assign ready      = (state_q == READY);
  assign card_valid = valid_q;
  assign card_rank  = rank_q;
  assign card_value = value_q;
  assign cards_left = cards_left_q;
  assign low_cards  = low_q;

endmodule

// File: tb/tb_card_shoe.sv
// Directed bench for the card shoe: fixed-order dealing, exhaustion with
// auto-reshuffle, random dealing coverage, low-card flag, request priority
// and reset during a probe.
module tb_card_shoe;

  logic       clk;
  logic       reset;
  logic       draw_req;
  logic       shuffle_req;
  logic       test_mode;
  logic       ready;
  logic       card_valid;
  logic [3:0] card_rank;
  logic [3:0] card_value;
  logic [5:0] cards_left;
  logic       low_cards;

  int checks;
  int failures;

  card_shoe #(
    .LFSR_SEED(16'hACE1),
    .LOW_MARK (13)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .draw_req   (draw_req),
    .shuffle_req(shuffle_req),
    .test_mode  (test_mode),
    .ready      (ready),
    .card_valid (card_valid),
    .card_rank  (card_rank),
    .card_value (card_value),
    .cards_left (cards_left),
    .low_cards  (low_cards)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hand-rule for card value: faces are 10, everything else its rank.
  function automatic logic [3:0] exp_value(input logic [3:0] r);
    return (r > 4'd10) ? 4'd10 : r;
  endfunction

  task automatic apply_reset();
    draw_req    = 1'b0;
    shuffle_req = 1'b0;
    reset       = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  // Waits for ready, issues a one-cycle draw, and reports the card and the
  // cycle distance from the request cycle to card_valid.
  task automatic do_draw(input logic tm, output logic [3:0] r, output logic [3:0] v,
                         output int lat, output logic ok);
    int w;
    ok  = 1'b0;
    lat = 0;
    r   = 4'd0;
    v   = 4'd0;
    w   = 0;
    while (!ready && w < 100) begin
      @(posedge clk);
      #1;
      w++;
    end
    draw_req  = 1'b1;
    test_mode = tm;
    @(posedge clk);
    #1;
    draw_req = 1'b0;
    lat = 1;
    for (int i = 0; i < 60; i++) begin
      @(posedge clk);
      #1;
      lat++;
      if (card_valid) begin
        ok = 1'b1;
        r  = card_rank;
        v  = card_value;
        break;
      end
    end
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL draw_timeout: card_valid=0 after %0d cycles, required a card", lat);
    end
    $display("draw tm=%0d rank=%0d value=%0d lat=%0d left=%0d low=%0d", tm, r, v, lat, cards_left, low_cards);
  endtask

  task automatic test_reset();
    apply_reset();
    checks += 6;
    if (ready !== 1'b1)      begin failures++; $display("FAIL reset_ready: got %0b want 1", ready); end
    if (card_valid !== 1'b0) begin failures++; $display("FAIL reset_valid: got %0b want 0", card_valid); end
    if (card_rank !== 4'd0)  begin failures++; $display("FAIL reset_rank: got %0d want 0", card_rank); end
    if (card_value !== 4'd0) begin failures++; $display("FAIL reset_value: got %0d want 0", card_value); end
    if (cards_left !== 6'd52) begin failures++; $display("FAIL reset_left: got %0d want 52", cards_left); end
    if (low_cards !== 1'b0)  begin failures++; $display("FAIL reset_low: got %0b want 0", low_cards); end
  endtask

  task automatic test_ordered();
    logic [3:0] r, v, er;
    int lat;
    logic ok;
    apply_reset();
    for (int i = 0; i < 14; i++) begin
      do_draw(1'b1, r, v, lat, ok);
      er = 4'((i % 13) + 1);
      checks += 4;
      if (r !== er) begin failures++; $display("FAIL ord_rank[%0d]: got %0d want %0d", i, r, er); end
      if (v !== exp_value(er)) begin failures++; $display("FAIL ord_value[%0d]: got %0d want %0d", i, v, exp_value(er)); end
      if (cards_left !== 6'(51 - i)) begin failures++; $display("FAIL ord_left[%0d]: got %0d want %0d", i, cards_left, 51 - i); end
      if (lat != 2) begin failures++; $display("FAIL ord_latency[%0d]: got %0d want 2", i, lat); end
      @(posedge clk);
      #1;
      checks++;
      if (ready !== 1'b1) begin failures++; $display("FAIL ord_ready_back[%0d]: got %0b want 1", i, ready); end
    end
  endtask

  task automatic test_exhaust();
    logic [3:0] r, v, er;
    int lat;
    logic ok;
    apply_reset();
    for (int i = 0; i < 52; i++) begin
      do_draw(1'b1, r, v, lat, ok);
      er = 4'((i % 13) + 1);
      checks++;
      if (r !== er) begin failures++; $display("FAIL exh_rank[%0d]: got %0d want %0d", i, r, er); end
    end
    checks += 2;
    if (cards_left !== 6'd0) begin failures++; $display("FAIL exh_empty_left: got %0d want 0", cards_left); end
    if (low_cards !== 1'b1)  begin failures++; $display("FAIL exh_empty_low: got %0b want 1", low_cards); end
    do_draw(1'b1, r, v, lat, ok);
    checks += 3;
    if (lat != 3)             begin failures++; $display("FAIL exh_reshuffle_latency: got %0d want 3", lat); end
    if (r !== 4'd1)           begin failures++; $display("FAIL exh_reshuffle_rank: got %0d want 1", r); end
    if (cards_left !== 6'd51) begin failures++; $display("FAIL exh_reshuffle_left: got %0d want 51", cards_left); end
  endtask

  task automatic test_random();
    logic [3:0] r, v;
    int lat;
    logic ok;
    int counts [16];
    apply_reset();
    for (int k = 0; k < 16; k++) counts[k] = 0;
    for (int i = 0; i < 52; i++) begin
      do_draw(1'b0, r, v, lat, ok);
      if (ok) counts[r]++;
      checks++;
      if (v !== exp_value(r)) begin failures++; $display("FAIL rnd_value[%0d]: rank %0d got %0d want %0d", i, r, v, exp_value(r)); end
    end
    for (int k = 1; k <= 13; k++) begin
      checks++;
      if (counts[k] != 4) begin failures++; $display("FAIL rnd_rank_count[%0d]: got %0d want 4", k, counts[k]); end
    end
    checks++;
    if (cards_left !== 6'd0) begin failures++; $display("FAIL rnd_empty_left: got %0d want 0", cards_left); end
    do_draw(1'b0, r, v, lat, ok);
    checks += 3;
    if (lat != 3)             begin failures++; $display("FAIL rnd_reshuffle_latency: got %0d want 3", lat); end
    if (cards_left !== 6'd51) begin failures++; $display("FAIL rnd_reshuffle_left: got %0d want 51", cards_left); end
    if (r < 4'd1 || r > 4'd13) begin failures++; $display("FAIL rnd_reshuffle_rank: got %0d want 1..13", r); end
  endtask

  task automatic test_low_and_shuffle();
    logic [3:0] r, v;
    int lat;
    logic ok;
    apply_reset();
    for (int i = 0; i < 40; i++) begin
      do_draw(1'b1, r, v, lat, ok);
      checks += 2;
      if (cards_left !== 6'(51 - i)) begin failures++; $display("FAIL low_left[%0d]: got %0d want %0d", i, cards_left, 51 - i); end
      if (low_cards !== (i >= 38)) begin failures++; $display("FAIL low_flag[%0d]: got %0b want %0b", i, low_cards, (i >= 38)); end
    end
    @(posedge clk);
    #1;
    shuffle_req = 1'b1;
    @(posedge clk);
    #1;
    shuffle_req = 1'b0;
    checks++;
    if (ready !== 1'b0) begin failures++; $display("FAIL shuf_ready_low: got %0b want 0", ready); end
    @(posedge clk);
    #1;
    checks += 3;
    if (ready !== 1'b1)       begin failures++; $display("FAIL shuf_ready_back: got %0b want 1", ready); end
    if (cards_left !== 6'd52) begin failures++; $display("FAIL shuf_left: got %0d want 52", cards_left); end
    if (low_cards !== 1'b0)   begin failures++; $display("FAIL shuf_low: got %0b want 0", low_cards); end
    $display("shuffle left=%0d low=%0d", cards_left, low_cards);
  endtask

  task automatic test_collision();
    logic [3:0] r, v, seen_rank;
    int lat;
    logic ok;
    int pulses;
    apply_reset();
    do_draw(1'b1, r, v, lat, ok);
    @(posedge clk);
    #1;
    draw_req    = 1'b1;
    shuffle_req = 1'b1;
    test_mode   = 1'b1;
    @(posedge clk);
    #1;
    draw_req    = 1'b0;
    shuffle_req = 1'b0;
    checks++;
    if (ready !== 1'b0) begin failures++; $display("FAIL coll_ready_low: got %0b want 0", ready); end
    pulses = 0;
    repeat (4) begin
      if (card_valid) pulses++;
      @(posedge clk);
      #1;
    end
    checks += 3;
    if (pulses != 0)          begin failures++; $display("FAIL coll_no_card: got %0d pulses want 0", pulses); end
    if (cards_left !== 6'd52) begin failures++; $display("FAIL coll_left: got %0d want 52", cards_left); end
    if (ready !== 1'b1)       begin failures++; $display("FAIL coll_ready_back: got %0b want 1", ready); end
    $display("collision pulses=%0d left=%0d", pulses, cards_left);

    // Hold draw_req through PROBE and DELIVER; only the first cycle counts.
    pulses    = 0;
    seen_rank = 4'd0;
    draw_req  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      if (card_valid) begin pulses++; seen_rank = card_rank; end
    end
    draw_req = 1'b0;
    repeat (5) begin
      @(posedge clk);
      #1;
      if (card_valid) pulses++;
    end
    checks += 3;
    if (pulses != 1)          begin failures++; $display("FAIL busy_pulses: got %0d want 1", pulses); end
    if (cards_left !== 6'd51) begin failures++; $display("FAIL busy_left: got %0d want 51", cards_left); end
    if (seen_rank !== 4'd1)   begin failures++; $display("FAIL busy_rank: got %0d want 1", seen_rank); end
    $display("busy_draw pulses=%0d left=%0d", pulses, cards_left);
  endtask

  task automatic test_reset_probe();
    logic [3:0] r, v;
    int lat;
    logic ok;
    int pulses;
    apply_reset();
    do_draw(1'b1, r, v, lat, ok);
    do_draw(1'b1, r, v, lat, ok);
    @(posedge clk);
    #1;
    draw_req  = 1'b1;
    test_mode = 1'b1;
    @(posedge clk);
    #1;
    draw_req = 1'b0;
    checks++;
    if (ready !== 1'b0) begin failures++; $display("FAIL rprobe_busy: got %0b want 0", ready); end
    reset = 1'b1;
    #1;
    checks += 3;
    if (ready !== 1'b1)       begin failures++; $display("FAIL rprobe_ready: got %0b want 1", ready); end
    if (cards_left !== 6'd52) begin failures++; $display("FAIL rprobe_left: got %0d want 52", cards_left); end
    if (card_valid !== 1'b0)  begin failures++; $display("FAIL rprobe_valid: got %0b want 0", card_valid); end
    @(posedge clk);
    #1;
    reset  = 1'b0;
    pulses = 0;
    repeat (4) begin
      @(posedge clk);
      #1;
      if (card_valid) pulses++;
    end
    checks++;
    if (pulses != 0) begin failures++; $display("FAIL rprobe_dropped: got %0d pulses want 0", pulses); end
    do_draw(1'b1, r, v, lat, ok);
    checks += 2;
    if (r !== 4'd1) begin failures++; $display("FAIL rprobe_first_rank: got %0d want 1", r); end
    if (lat != 2)   begin failures++; $display("FAIL rprobe_latency: got %0d want 2", lat); end
  endtask

  initial begin
    checks      = 0;
    failures    = 0;
    reset       = 1'b1;
    draw_req    = 1'b0;
    shuffle_req = 1'b0;
    test_mode   = 1'b1;
    test_reset();
    test_ordered();
    test_exhaust();
    test_random();
    test_low_and_shuffle();
    test_collision();
    test_reset_probe();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/card_shoe.md
Name: card_shoe

Overview:
- Single 52-card shoe that deals without replacement, feeding the blackjack game FSM one card per request.
- Replaces free-running per-cycle card values with a draw handshake, so a card is never dealt twice until the shoe is shuffled.
- Supports random dealing from an LFSR and a deterministic test order.
- Sits directly upstream of the game FSM; the FSM requests a card and consumes `card_value`.

Parameters:
- LFSR_SEED, 16'hACE1, value loaded into the LFSR on reset; must be non-zero.
- LOW_MARK, 13, `low_cards` asserts when `cards_left` <= LOW_MARK.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- draw_req  in  1  one-cycle request for a card; accepted only when ready=1
- shuffle_req  in  1  one-cycle request to return all cards to the shoe; accepted only when ready=1
- test_mode  in  1  1 = deal in fixed index order; sampled at draw acceptance
- ready  out  1  shoe idle; requests accepted this cycle
- card_valid  out  1  one-cycle pulse; card outputs valid in that cycle
- card_rank  out  4  1..13 (A,2..10,J,Q,K)
- card_value  out  4  blackjack value 1..10 (J/Q/K=10, Ace=1)
- cards_left  out  6  undealt cards, 0..52
- low_cards  out  1  cards_left <= LOW_MARK

Behaviour:
- Reset (async, any state):
  - state=READY, used mask cleared, cards_left=52, LFSR=LFSR_SEED.
  - card_valid=0, card_rank=0, card_value=0, ready=1, low_cards=0.
  - A reset mid-draw drops that draw with no card_valid pulse.
- Card index idx 0..51: rank = (idx mod 13)+1; value = min(rank,10); suit = idx/13 (internal only).
- LFSR:
  - 16-bit Galois, taps 16'hB400, shifts every cycle.
  - Candidate index = lfsr[5:0], minus 52 when >=52.
- States: READY, SHUFFLE, PROBE, DELIVER.
- READY (ready=1):
  - shuffle_req → SHUFFLE. shuffle_req wins if both requests arrive in the same cycle; that draw_req is ignored.
  - draw_req with cards_left>0 → PROBE.
    - probe_idx = candidate if test_mode=0.
    - probe_idx = 52-cards_left if test_mode=1.
  - draw_req with cards_left==0 → SHUFFLE with pending_draw=1 (automatic reshuffle).
  - Requests arriving while ready=0 are dropped. The requester re-issues after ready returns.
- SHUFFLE (1 cycle):
  - Clear used mask, cards_left=52.
  - pending_draw=1 → PROBE, with probe_idx chosen by the same rule as READY (52-cards_left is taken as 0); clear pending_draw.
  - Otherwise → READY.
- PROBE:
  - used[probe_idx]=0 → set used bit, register rank/value, cards_left -= 1, → DELIVER.
  - used[probe_idx]=1 → probe_idx+1, wrapping 51→0, stay in PROBE.
  - Since cards_left>0 on entry, at most 52 probe cycles.
- DELIVER: card_valid=1 for one cycle with card_rank/card_value held; → READY. card_rank/card_value hold their values until the next DELIVER.
- Latency: draw_req in cycle N → card_valid in cycle N+2+k, where k = used slots skipped; ready high again at N+3+k.
  - Test mode on a fresh shoe: k=0, so latency is 2.
  - Automatic reshuffle adds 1 cycle.
- Outputs are registers, except `ready`, which decodes state==READY.

Decomposition:
- Shared package blackjack_pkg:
  - DECK_SIZE=52, RANKS=13, FACE_VALUE=10.
  - shoe_state_t enum {READY,SHUFFLE,PROBE,DELIVER}.
  - rank_to_value function, reused by the game FSM.
- Sub-module card_lfsr16:
  - Ports: clk, reset, seed parameter, 16-bit state output.
- Index-to-rank mapping stays inline.

Test Plan:
- Reset, test_mode=1, 14 draws (one per ready) → ranks 1..13,1; values 1..10,10,10,10,1; cards_left 51..38; each latency 2 cycles.
- test_mode=1, 52 draws then one more draw → 53rd incurs auto-shuffle: card_valid at N+3, rank 1, cards_left 51.
- test_mode=0, 52 draws → all 52 indices distinct (each rank seen exactly 4 times); cards_left 0; 53rd draw reshuffles.
- 40 draws (test_mode=1) → low_cards rises when cards_left hits 13 (after draw 39); shuffle_req → cards_left=52, low_cards=0, ready low exactly 1 cycle.
- draw_req and shuffle_req high in the same READY cycle → shuffle only, no card_valid; draw_req while ready=0 → ignored, cards_left unchanged.
- Assert reset during PROBE → no card_valid, cards_left=52, ready=1 immediately; first post-reset test-mode draw returns rank 1.
